// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sadd_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the legal operand width range.
package gf180mcu_fd_sc_mcu7t5v0__sadd_pkg;

    localparam int SADD_WIDTH_MIN = 2;
    localparam int SADD_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sadd_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_func.sv
// Functional model of the library full-adder cell: one-bit sum and carry.
module gf180mcu_fd_sc_mcu7t5v0__addf_func (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sadd_seq.sv
// Bit-serial adder: feeds one LSB-first bit pair per cycle through a single
// full-adder cell. Define GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN to add SUB (A-B).
module gf180mcu_fd_sc_mcu7t5v0__sadd_seq
    import gf180mcu_fd_sc_mcu7t5v0__sadd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if ((WIDTH < SADD_WIDTH_MIN) || (WIDTH > SADD_WIDTH_MAX)) begin : g_width_check
        $error("gf180mcu_fd_sc_mcu7t5v0__sadd_seq: WIDTH out of range");
    end

    sadd_state_e      state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             faB;
    logic             faS;
    logic             faCo;
    logic             loadCarry;

`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
    logic             sub_q, sub_d;

    // Subtraction is A + ~B + 1: invert B per bit and seed the carry with 1.
    assign faB       = bSh_q[0] ^ sub_q;
    assign loadCarry = SUB;
`else
    assign faB       = bSh_q[0];
    assign loadCarry = 1'b0;
`endif

    gf180mcu_fd_sc_mcu7t5v0__addf_func u_addf (
        .A  (aSh_q[0]),
        .B  (faB),
        .CI (carry_q),
        .S  (faS),
        .CO (faCo)
    );

    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    aSh_d   = A_IN;
                    bSh_d   = B_IN;
                    sum_d   = '0;
                    cnt_d   = '0;
                    carry_d = loadCarry;
                    cout_d  = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
                    sub_d   = SUB;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = {faS, sum_q[WIDTH-1:1]};
                carry_d = faCo;
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Counter parks at zero outside RUN so it can never wrap.
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    cout_d  = faCo;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);
    assign SUM  = sum_q;
    assign COUT = cout_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__sadd_seq.md
Name: gf180mcu_fd_sc_mcu7t5v0__sadd_seq

Overview:
- Bit-serial adder datapath built around the library full-adder cell; it is the sequencing stage that drives the cell.
- Each cycle it presents one LSB-first bit pair on A/B to the cell and feeds the cell's previous CO back on CI through a carry flip-flop.
- It shifts S into a result register.
- Used as a minimum-area adder/accumulator in slow-control paths of the 7-track 5V library.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE or DONE.
- A_IN  input  WIDTH  operand A; captured on accepted START.
- B_IN  input  WIDTH  operand B; captured on accepted START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  high while SUM/COUT are valid for the last operation.
- SUM  output  WIDTH  result, A+B mod 2^WIDTH.
- COUT  output  1  carry out of the MSB.

Behaviour:
- Interface: single clock, CLK; reset RN is asynchronous and active-low. All state is reset asynchronously on RN=0 and released on the CLK edge after deassertion.
- Reset values: BUSY=0, DONE=0, SUM=0, COUT=0, state=IDLE, carry flop=0, counter=0.
- States:
  - IDLE: START=1 → load shift regs A_sh=A_IN, B_sh=B_IN; carry=0; cnt=0; SUM cleared; DONE=0; go to RUN.
  - RUN: BUSY=1. On each edge:
    - Full-adder inputs are A_sh[0], B_sh[0], carry.
    - The cell's S shifts into SUM MSB (SUM >> 1 with S at bit WIDTH-1).
    - The cell's CO loads carry.
    - A_sh and B_sh shift right; cnt increments.
    - When cnt reaches WIDTH-1 on this edge (last bit), go to DONE; COUT takes the CO of that bit.
  - DONE: BUSY=0, DONE=1; SUM/COUT held stable. START=1 → behaves as in IDLE (restart, DONE drops on that edge). Otherwise stays in DONE indefinitely.
- Latency: START accepted at edge 0 → RUN for exactly WIDTH edges → DONE=1 after edge WIDTH. Throughput is one operation per WIDTH+1 cycles with START held high.
- START while BUSY is ignored; operands are not re-sampled.
- Operand inputs are don't-care outside the accepting edge.
- RN asserted mid-RUN: operation is abandoned and all outputs return to reset values immediately; no partial result is reported.
- Arithmetic: unsigned; SUM = (A+B)[WIDTH-1:0]; COUT = (A+B)[WIDTH].
- The carry flop is never cleared in RUN; it is cleared only at load.
- BUSY and DONE are never simultaneously high.
- Counter wrap is impossible by construction; cnt is held at 0 outside RUN.

Optional Feature:
- Macro: GF180MCU_FD_SC_MCU7T5V0__SADD_SEQ_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), captured with operands on accepted START.
  - SUB=1 feeds ~B_sh[0] to the cell and initialises carry=1, giving SUM = A−B mod 2^WIDTH and COUT = 1 when A≥B (no borrow).
  - SUB=0 is identical to the base behaviour.
- Undefined: no SUB port; add only; carry is initialised to 0.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu7t5v0__sadd_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the WIDTH legality bounds.
- Sub-module: one instance of the library's full-adder functional model (gf180mcu_fd_sc_mcu7t5v0__addf_func) for the per-bit sum/carry. All sequencing, shift registers and the carry flop live in the top.

Test Plan:
- WIDTH=8, A_IN=8'h35, B_IN=8'h4A, START pulse → BUSY high 8 cycles, then DONE=1, SUM=8'h7F, COUT=0.
- A_IN=8'hFF, B_IN=8'h01 → SUM=8'h00, COUT=1; DONE holds for 20 idle cycles with SUM unchanged.
- START re-pulsed at cycle 3 of RUN with new operands → ignored; result still reflects the first operands; DONE after exactly 8 RUN edges.
- RN pulled low at RUN cycle 5 → BUSY=0, DONE=0, SUM=0, COUT=0 asynchronously. A new START after release gives a correct result (8'h10+8'h20 → 8'h30).
- START held high continuously → back-to-back operations with DONE high one cycle out of every 9; each SUM matches its operands.
- With SUB_EN defined, SUB=1, A=8'h10, B=8'h11 → SUM=8'hFF, COUT=0. A=8'h11, B=8'h10 → SUM=8'h01, COUT=1.
